// File: rtl/ds_issue_scoreboard.sv
// Register-dependency scoreboard for the decode stage: counts uncommitted GPR writes per register
// and derives ds_ready_go from RAW hazards and scoreboard / pipeline capacity.
module ds_issue_scoreboard #(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_valid,
    input  logic        es_allowin,
    input  logic        ds_gr_we,
    input  logic [4:0]  ds_dest,
    input  logic        ds_src1_used,
    input  logic [4:0]  ds_src1,
    input  logic        ds_src2_used,
    input  logic [4:0]  ds_src2,
    input  logic        ws_rf_we,
    input  logic [4:0]  ws_rf_waddr,
    input  logic        flush,
    output logic        ds_ready_go,
    output logic [31:0] pending_mask,
    output logic [1:0]  inflight_cnt,
    output logic        sb_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [1:0]       INF_ZERO = 2'd0;
    localparam logic [1:0]       INF_ONE  = 2'd1;
    localparam logic [1:0]       INF_MAX  = 2'(MAX_INFLIGHT);

    // r0 is hard-wired zero, so it never takes part in tracking
    function automatic logic reg_live(input logic [4:0] addr);
        return (addr != 5'd0);
    endfunction

    logic [CNT_W-1:0] cnt_r     [32];
    logic [CNT_W-1:0] cnt_nxt_s [32];
    logic [1:0]       inflight_r;
    logic [1:0]       inflight_nxt_s;
    logic             sb_err_r;
    logic             sb_err_nxt_s;
    logic [31:0]      pending_mask_r;
    logic [31:0]      pending_nxt_s;

    logic             hazard1_s;
    logic             hazard2_s;
    logic             full_dest_s;
    logic             full_pipe_s;
    logic             ready_go_s;
    logic             dest_write_s;
    logic             issue_s;
    logic             retire_s;
    logic             retire_ok_s;
    logic             retire_bad_s;

    // Hazard and capacity checks look only at registered counters, never at this cycle's WB
    always_comb begin
        dest_write_s = ds_gr_we & reg_live(ds_dest);
        hazard1_s    = ds_src1_used & reg_live(ds_src1) & (cnt_r[ds_src1] != CNT_ZERO);
        hazard2_s    = ds_src2_used & reg_live(ds_src2) & (cnt_r[ds_src2] != CNT_ZERO);
        full_dest_s  = dest_write_s & (cnt_r[ds_dest] == CNT_MAX);
        full_pipe_s  = dest_write_s & (inflight_r == INF_MAX);
        ready_go_s   = ~(hazard1_s | hazard2_s | full_dest_s | full_pipe_s);
        issue_s      = ds_valid & es_allowin & ready_go_s & dest_write_s & ~flush;
        retire_s     = ws_rf_we & reg_live(ws_rf_waddr) & ~flush;
        retire_ok_s  = retire_s & (cnt_r[ws_rf_waddr] != CNT_ZERO);
        retire_bad_s = retire_s & (cnt_r[ws_rf_waddr] == CNT_ZERO);
    end

    // Next-state for counters, in-flight total and sticky error
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
        end
        inflight_nxt_s = inflight_r;
        sb_err_nxt_s   = sb_err_r;
        if (flush) begin
            for (int i = 0; i < 32; i++) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end
            inflight_nxt_s = INF_ZERO;
        end else begin
            // Issue and retire on the same register cancel because both edits stack here
            if (issue_s) begin
                cnt_nxt_s[ds_dest] = cnt_nxt_s[ds_dest] + CNT_ONE;
            end else begin
                cnt_nxt_s[ds_dest] = cnt_nxt_s[ds_dest];
            end
            if (retire_ok_s) begin
                cnt_nxt_s[ws_rf_waddr] = cnt_nxt_s[ws_rf_waddr] - CNT_ONE;
            end else begin
                cnt_nxt_s[ws_rf_waddr] = cnt_nxt_s[ws_rf_waddr];
            end
            case ({issue_s, retire_ok_s})
                2'b10:   inflight_nxt_s = inflight_r + INF_ONE;
                2'b01:   inflight_nxt_s = inflight_r - INF_ONE;
                default: inflight_nxt_s = inflight_r;
            endcase
            if (retire_bad_s) begin
                sb_err_nxt_s = 1'b1;
            end else begin
                sb_err_nxt_s = sb_err_r;
            end
        end
    end

    // Pending mask is precomputed from next counter values so the output comes from a flop
    always_comb begin
        pending_nxt_s = 32'd0;
        for (int i = 1; i < 32; i++) begin
            pending_nxt_s[i] = (cnt_nxt_s[i] != CNT_ZERO);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            inflight_r     <= INF_ZERO;
            sb_err_r       <= 1'b0;
            pending_mask_r <= 32'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            inflight_r     <= inflight_nxt_s;
            sb_err_r       <= sb_err_nxt_s;
            pending_mask_r <= pending_nxt_s;
        end
    end

    assign ds_ready_go  = ready_go_s;
    assign pending_mask = pending_mask_r;
    assign inflight_cnt = inflight_r;
    assign sb_err       = sb_err_r;

endmodule

// File: tb/tb_ds_issue_scoreboard.sv
// Directed self-checking bench for ds_issue_scoreboard.
module tb_ds_issue_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_valid, es_allowin, ds_gr_we;
    logic [4:0]  ds_dest;
    logic        ds_src1_used, ds_src2_used;
    logic [4:0]  ds_src1, ds_src2;
    logic        ws_rf_we;
    logic [4:0]  ws_rf_waddr;
    logic        flush;
    logic        ds_ready_go;
    logic [31:0] pending_mask;
    logic [1:0]  inflight_cnt;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    ds_issue_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(3)) dut (
        .clk(clk), .resetn(resetn),
        .ds_valid(ds_valid), .es_allowin(es_allowin), .ds_gr_we(ds_gr_we), .ds_dest(ds_dest),
        .ds_src1_used(ds_src1_used), .ds_src1(ds_src1),
        .ds_src2_used(ds_src2_used), .ds_src2(ds_src2),
        .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .flush(flush),
        .ds_ready_go(ds_ready_go), .pending_mask(pending_mask),
        .inflight_cnt(inflight_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] mask, input logic [1:0] inf,
                             input logic err);
        chk({tag, "_mask"}, pending_mask, mask);
        chk({tag, "_inf"}, {30'd0, inflight_cnt}, {30'd0, inf});
        chk({tag, "_err"}, {31'd0, sb_err}, {31'd0, err});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic we, input logic [4:0] d,
                       input logic u1, input logic [4:0] s1, input logic u2, input logic [4:0] s2);
        ds_valid = v; es_allowin = 1'b1; ds_gr_we = we; ds_dest = d;
        ds_src1_used = u1; ds_src1 = s1; ds_src2_used = u2; ds_src2 = s2;
    endtask

    task automatic wb(input logic we, input logic [4:0] a);
        ws_rf_we = we; ws_rf_waddr = a;
    endtask

    task automatic rdy(input string tag, input logic exp);
        #1;
        chk(tag, {31'd0, ds_ready_go}, {31'd0, exp});
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0;
        dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        es_allowin = 1'b0;
        wb(1'b0, 5'd0);
        #2;
        chk_state("reset", 32'h0, 2'd0, 1'b0);
        chk("reset_rdy", {31'd0, ds_ready_go}, 32'd1);
        #10 resetn = 1'b1;
        tick();

        // RAW on r5 through src1
        dec(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        rdy("raw_issue_rdy", 1'b1);
        tick();
        chk_state("raw_issued", 32'h0000_0020, 2'd1, 1'b0);
        dec(1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        rdy("raw_stall0", 1'b0);
        tick();
        rdy("raw_stall1", 1'b0);
        wb(1'b1, 5'd5);
        rdy("raw_same_cycle_retire", 1'b0);
        tick();
        wb(1'b0, 5'd0);
        chk_state("raw_retired", 32'h0, 2'd0, 1'b0);
        rdy("raw_released", 1'b1);
        tick();

        // src2 hazard on r12
        dec(1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12);
        rdy("src2_hazard", 1'b0);
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12);
        rdy("src2_unused", 1'b1);
        wb(1'b1, 5'd12);
        tick();
        wb(1'b0, 5'd0);
        chk_state("src2_done", 32'h0, 2'd0, 1'b0);

        // Same-cycle issue and retire on r7
        dec(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        chk_state("r7_one", 32'h0000_0080, 2'd1, 1'b0);
        wb(1'b1, 5'd7);
        rdy("r7_both_rdy", 1'b1);
        tick();
        chk_state("r7_both", 32'h0000_0080, 2'd1, 1'b0);
        dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        wb(1'b0, 5'd0);
        chk_state("r7_drained", 32'h0, 2'd0, 1'b0);

        // r0 is never tracked or stalled on
        dec(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        wb(1'b1, 5'd0);
        rdy("r0_rdy", 1'b1);
        tick();
        wb(1'b0, 5'd0);
        chk_state("r0_noop", 32'h0, 2'd0, 1'b0);

        // Capacity: r1, r2, r3 back-to-back fill the pipe
        dec(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        dec(1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        dec(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        chk_state("cap_full", 32'h0000_000E, 2'd3, 1'b0);
        dec(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        rdy("cap_writer_stall", 1'b0);
        dec(1'b1, 1'b0, 5'd4, 1'b1, 5'd10, 1'b0, 5'd0);
        rdy("cap_nonwriter_go", 1'b1);
        dec(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        rdy("cap_r0_writer_go", 1'b1);
        dec(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        chk_state("cap_held", 32'h0000_000E, 2'd3, 1'b0);

        // Spurious retire of r9, then flush with writes pending
        dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        wb(1'b1, 5'd9);
        tick();
        chk_state("spurious", 32'h0000_000E, 2'd3, 1'b1);
        wb(1'b1, 5'd2);
        flush = 1'b1;
        dec(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        flush = 1'b0;
        wb(1'b0, 5'd0);
        dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk_state("flushed", 32'h0, 2'd0, 1'b1);
        tick();
        chk_state("sticky", 32'h0, 2'd0, 1'b1);

        // Asynchronous reset in the middle of a run
        dec(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk_state("pre_reset", 32'h0000_0040, 2'd1, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk_state("async_reset", 32'h0, 2'd0, 1'b0);
        #3 resetn = 1'b1;
        tick();
        chk_state("post_reset", 32'h0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
